// File: rtl/ifetch_queue_if.sv
// Instruction-memory fetch bus between the fetch queue and imem.
// One outstanding word request, completed by a single-cycle ack.
interface ifetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_queue.sv
// Prefetching instruction-fetch front end: issues imem requests and
// buffers {instruction, PC+4} pairs ahead of the IF/ID register.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  ifetch_queue_if.master    imem,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              stall,
  output logic              if_valid,
  output logic [31:0]       if_ins,
  output logic [31:0]       if_pcadd4,
  output logic [CW-1:0]     queue_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e        state_q;
  logic          req_q;
  logic [31:0]   pc_q;
  logic [31:0]   addr_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   pca_q [DEPTH];

  logic          ack;
  logic          pop;
  logic          push;
  logic          space;
  logic [CW-1:0] cnt_d;
  logic [31:0]   pc_inc;
  logic [31:0]   tgt;

  assign if_valid    = (cnt_q != '0);
  assign if_ins      = if_valid ? ins_q[rd_q] : '0;
  assign if_pcadd4   = if_valid ? pca_q[rd_q] : '0;
  assign queue_count = cnt_q;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  always_comb begin
    ack    = imem.imem_ack && (state_q != IDLE);
    pop    = if_valid && !stall && !redirect;
    push   = (state_q == REQ) && ack && !redirect;
    cnt_d  = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    space  = (cnt_d < CW'(DEPTH));
    pc_inc = pc_q + 32'd4;
    tgt    = redirect ? redirect_pc : pc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pca_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (redirect) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) begin
          ins_q[wr_q] <= imem.imem_rdata;
          pca_q[wr_q] <= pc_inc;
          wr_q        <= wr_q + 1'b1;
        end
        if (pop) rd_q <= rd_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          pc_q <= tgt;
          if (space) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= tgt;
          end
        end
        REQ: begin
          if (redirect) begin
            pc_q <= redirect_pc;
            if (ack) addr_q <= redirect_pc;
            else     state_q <= DROP;
          end else if (ack) begin
            pc_q   <= pc_inc;
            addr_q <= pc_inc;
            if (!space) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        DROP: begin
          // Stale address stays on the bus until its ack is absorbed
          pc_q <= tgt;
          if (ack) begin
            addr_q <= tgt;
            if (space) begin
              state_q <= REQ;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && !pop && cnt_q == CW'(DEPTH))
  );

endmodule
